// File: rtl/cpri_pkg.sv
// Shared constants, FSM state type and header packing helpers for the CPRI RX
// packet writer.
package cpri_pkg;

   localparam logic [15:0] SYNC_WORD      = 16'hA5C3;
   localparam int          HDR_WORDS      = 3;
   localparam int          PAYLOAD_WORDS  = 96;
   localparam logic [6:0]  FIRST_PAY_ADDR = 7'd3;
   localparam logic [6:0]  LAST_PAY_ADDR  = 7'd98;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_HEADER  = 2'd2,
      ST_DROP    = 2'd3
   } state_e;

   function automatic logic [63:0] hdr_word0(input logic [15:0] seq);
      return {SYNC_WORD, seq, 32'd0};
   endfunction

   function automatic logic [63:0] hdr_word1(input logic [11:0] frame, input logic [6:0] slot);
      return {20'd0, frame, 25'd0, slot};
   endfunction

   function automatic logic [63:0] hdr_word2(input logic [15:0] drops, input logic [15:0] errs);
      return {16'(PAYLOAD_WORDS), drops, errs, 16'd0};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

endpackage

// File: rtl/cpri_rx_pkt_wr.sv
// Packs 96-word deframed IQ chunks into 99-word addressed packets (payload at
// 3..98, header at 0..2) and drives the RX loop-buffer write port.
module cpri_rx_pkt_wr #(
   parameter int DATA_WIDTH    = 64,
   parameter int ADDR_WIDTH    = 7,
   parameter int PAYLOAD_WORDS = 96,
   parameter int HDR_WORDS     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_rx_valid,
   input  logic                  i_rx_sop,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic [11:0]           i_frame_num,
   input  logic [6:0]            i_slot_num,
   input  logic                  i_enable,
   input  logic                  i_tready,
   output logic                  o_cpri_wen,
   output logic [ADDR_WIDTH-1:0] o_cpri_waddr,
   output logic [DATA_WIDTH-1:0] o_cpri_wdata,
   output logic                  o_cpri_wlast,
   output logic [15:0]           o_drop_cnt,
   output logic [15:0]           o_err_cnt
);
   import cpri_pkg::*;

   localparam logic [6:0] LAST_CNT = 7'(PAYLOAD_WORDS - 1);
   localparam logic [1:0] HDR_LAST = 2'(HDR_WORDS - 1);

   state_e                r_state;
   logic [6:0]            r_cnt;
   logic [1:0]            r_hdr_idx;
   logic [15:0]           r_seq;
   logic [11:0]           r_frame;
   logic [6:0]            r_slot;
   logic [15:0]           r_drop_cnt;
   logic [15:0]           r_err_cnt;
   logic [15:0]           r_snap_drop;
   logic [15:0]           r_snap_err;
   logic                  r_pend_drop;
   logic                  r_wen;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_wlast;

   logic w_sop;
   logic w_admit;
   logic w_start;
   logic w_pay_last;
   logic w_hdr_last;

   // SOP decode; a SOP during the header never starts a chunk immediately
   always_comb begin
      w_sop      = i_rx_valid & i_rx_sop;
      w_admit    = i_enable & i_tready;
      w_start    = w_sop & (r_state != ST_HEADER);
      w_pay_last = (r_cnt == LAST_CNT);
      w_hdr_last = (r_hdr_idx == HDR_LAST);
   end

   // Packet FSM, write port and statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 7'd0;
         r_hdr_idx   <= 2'd0;
         r_seq       <= 16'd0;
         r_frame     <= 12'd0;
         r_slot      <= 7'd0;
         r_drop_cnt  <= 16'd0;
         r_err_cnt   <= 16'd0;
         r_snap_drop <= 16'd0;
         r_snap_err  <= 16'd0;
         r_pend_drop <= 1'b0;
         r_wen       <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_wlast     <= 1'b0;
      end else begin
         r_wen   <= 1'b0;
         r_wlast <= 1'b0;
         if (w_start) begin
            // A SOP inside a payload is a short chunk: abandon it uncommitted
            if (r_state == ST_PAYLOAD) begin
               r_err_cnt <= sat_inc16(r_err_cnt);
            end
            r_cnt <= 7'd1;
            if (w_admit) begin
               r_frame <= i_frame_num;
               r_slot  <= i_slot_num;
               r_wen   <= 1'b1;
               r_waddr <= ADDR_WIDTH'(FIRST_PAY_ADDR);
               r_wdata <= i_rx_data;
               r_state <= ST_PAYLOAD;
            end else begin
               r_drop_cnt <= sat_inc16(r_drop_cnt);
               r_state    <= ST_DROP;
            end
         end else begin
            case (r_state)
               ST_PAYLOAD: begin
                  if (i_rx_valid) begin
                     r_wen   <= 1'b1;
                     r_waddr <= ADDR_WIDTH'(FIRST_PAY_ADDR + r_cnt);
                     r_wdata <= i_rx_data;
                     if (w_pay_last) begin
                        r_cnt       <= 7'd0;
                        r_hdr_idx   <= 2'd0;
                        r_snap_drop <= r_drop_cnt;
                        r_snap_err  <= r_err_cnt;
                        r_state     <= ST_HEADER;
                     end else begin
                        r_cnt <= r_cnt + 7'd1;
                     end
                  end
               end
               ST_HEADER: begin
                  r_wen   <= 1'b1;
                  r_waddr <= ADDR_WIDTH'(r_hdr_idx);
                  case (r_hdr_idx)
                     2'd0:    r_wdata <= DATA_WIDTH'(hdr_word0(r_seq));
                     2'd1:    r_wdata <= DATA_WIDTH'(hdr_word1(r_frame, r_slot));
                     default: r_wdata <= DATA_WIDTH'(hdr_word2(r_snap_drop, r_snap_err));
                  endcase
                  // A SOP arriving too early is dropped once the header is done
                  if (w_sop) begin
                     r_err_cnt   <= sat_inc16(r_err_cnt);
                     r_drop_cnt  <= sat_inc16(r_drop_cnt);
                     r_pend_drop <= 1'b1;
                     r_cnt       <= 7'd1;
                  end else if (i_rx_valid && r_pend_drop) begin
                     r_cnt <= r_cnt + 7'd1;
                  end
                  if (w_hdr_last) begin
                     r_wlast     <= 1'b1;
                     r_seq       <= r_seq + 16'd1;
                     r_hdr_idx   <= 2'd0;
                     r_pend_drop <= 1'b0;
                     r_state     <= (r_pend_drop || w_sop) ? ST_DROP : ST_IDLE;
                  end else begin
                     r_hdr_idx <= r_hdr_idx + 2'd1;
                  end
               end
               ST_DROP: begin
                  if (i_rx_valid) begin
                     if (w_pay_last) begin
                        r_cnt   <= 7'd0;
                        r_state <= ST_IDLE;
                     end else begin
                        r_cnt <= r_cnt + 7'd1;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_cpri_wen   = r_wen;
   assign o_cpri_waddr = r_waddr;
   assign o_cpri_wdata = r_wdata;
   assign o_cpri_wlast = r_wlast;
   assign o_drop_cnt   = r_drop_cnt;
   assign o_err_cnt    = r_err_cnt;

endmodule
